// File: rtl/wtu_pair_fifo_ctrl_if.sv
// rtl/wtu_pair_fifo_ctrl_if.sv - sample stream, memory write port and pair-read port bundle
// slave: the FIFO controller; master: the producer/consumer/memory side.
interface wtu_pair_fifo_ctrl_if #(
  parameter int WR_WIDTH = 24,
  parameter int WR_DEPTH = 8
);
  localparam int WA = $clog2(WR_DEPTH);
  localparam int RA = WA - 1;

  logic [WR_WIDTH-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [WA-1:0]       wr_addr;
  logic [WR_WIDTH-1:0] wr_data;
  logic                wr_en;
  logic [RA-1:0]       rd_addr;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, wr_addr, wr_data, wr_en, rd_addr, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, wr_addr, wr_data, wr_en, rd_addr, out_valid
  );
endinterface

// File: rtl/wtu_pair_fifo_ctrl.sv
// rtl/wtu_pair_fifo_ctrl.sv - pointer controller turning the WTU sample memory into a pair FIFO
// Optional zero-pad of an odd trailing sample on in_last: define WTU_PAD_ON_LAST_EN.
module wtu_pair_fifo_ctrl #(
  parameter int WR_WIDTH = 24,
  parameter int WR_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
`ifdef WTU_PAD_ON_LAST_EN
  input  logic                       in_last,
`endif
  wtu_pair_fifo_ctrl_if.slave        bus,
  output logic [$clog2(WR_DEPTH):0]  level,
  output logic                       ovf_err
);
  localparam int WA = $clog2(WR_DEPTH);
  localparam int RA = WA - 1;
  localparam logic [WA:0] FULL_OCC = (WA+1)'(WR_DEPTH);
  localparam logic [WA:0] PAIR_OCC = (WA+1)'(2);

  logic [WA:0] wp_q, wp_d;
  logic [RA:0] rp_q, rp_d;
  logic [WA:0] level_q, level_d;
  logic        ovf_q, ovf_d;

  logic [WA:0] occ;
  logic        full;
  logic        run;
  logic        rdy;
  logic        vld;
  logic        push;
  logic        pop;
  logic        pad_wr;
  logic        wr_any;

  // Occupancy in samples; the pair pointer is doubled to compare in sample units.
  assign occ  = wp_q - {rp_q, 1'b0};
  assign full = (occ == FULL_OCC);
  assign rdy  = ~full & run;
  assign vld  = (occ >= PAIR_OCC);

  // Gating with rst keeps the write strobe quiet while reset is held.
  assign push   = bus.in_valid & rdy & ~flush & rst;
  assign pop    = vld & bus.out_ready & ~flush;
  assign wr_any = push | pad_wr;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.wr_en     = wr_any;
  assign bus.wr_addr   = wp_q[WA-1:0];
  assign bus.wr_data   = pad_wr ? '0 : bus.in_data;
  assign bus.rd_addr   = rp_q[RA-1:0];
  assign level         = level_q;
  assign ovf_err       = ovf_q;

`ifdef WTU_PAD_ON_LAST_EN
  typedef enum logic {RUN = 1'b0, PAD = 1'b1} fsm_e;
  fsm_e fsm_q, fsm_d;

  assign run    = (fsm_q == RUN);
  assign pad_wr = (fsm_q == PAD) & ~full & ~flush & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm_q <= RUN;
    else      fsm_q <= fsm_d;
  end

  // A last sample landing on an even slot leaves its pair half-empty; pad it.
  always_comb begin
    fsm_d = fsm_q;
    if (flush) begin
      fsm_d = RUN;
    end else begin
      case (fsm_q)
        RUN:     if (push & in_last & ~wp_q[0]) fsm_d = PAD;
        PAD:     if (pad_wr) fsm_d = RUN;
        default: fsm_d = RUN;
      endcase
    end
  end
`else
  assign run    = 1'b1;
  assign pad_wr = 1'b0;
`endif

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
      ovf_d   = 1'b0;
    end else begin
      wp_d    = wp_q + {{WA{1'b0}}, wr_any};
      rp_d    = rp_q + {{RA{1'b0}}, pop};
      level_d = wp_d - {rp_d, 1'b0};
      if (bus.in_valid & ~rdy & run & full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_wtu_pair_fifo_ctrl.sv
// tb/tb_wtu_pair_fifo_ctrl.sv - scoreboard bench for the WTU pair FIFO controller
// Models the external sample memory and the expected pair stream.
module tb_wtu_pair_fifo_ctrl;
  localparam int W = 24;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_last = 1'b0;
  logic [3:0] level;
  logic       ovf_err;

  int total = 0;
  int bad = 0;
  int pops = 0;

  wtu_pair_fifo_ctrl_if #(.WR_WIDTH(W), .WR_DEPTH(D)) bus ();

  wtu_pair_fifo_ctrl #(.WR_WIDTH(W), .WR_DEPTH(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
`ifdef WTU_PAD_ON_LAST_EN
    .in_last (in_last),
`endif
    .bus     (bus.slave),
    .level   (level),
    .ovf_err (ovf_err)
  );

  always #5 clk = ~clk;

  logic [W-1:0]   mem [D];
  logic [2*W-1:0] rd_data;
  always @(posedge clk) if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  assign rd_data = {mem[{bus.rd_addr, 1'b1}], mem[{bus.rd_addr, 1'b0}]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [2*W-1:0] sb[$];
  logic [W-1:0]   half;
  logic           have_half = 1'b0;
  logic [2:0]     m_wp = '0;
  logic [1:0]     m_rp = '0;

  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      have_half = 1'b0;
      m_wp = '0;
      m_rp = '0;
    end else if (flush) begin
      chk("flush_wr_en", bus.wr_en, 1'b0);
      sb.delete();
      have_half = 1'b0;
      m_wp = '0;
      m_rp = '0;
    end else begin
      if (bus.wr_en) begin
        chk("wr_addr", bus.wr_addr, m_wp);
        m_wp = m_wp + 3'd1;
      end
      if (bus.in_valid && bus.in_ready) begin
        chk("push_wr_data", bus.wr_data, bus.in_data);
        if (have_half) begin
          sb.push_back({bus.in_data, half});
          have_half = 1'b0;
        end else begin
          half = bus.in_data;
          have_half = 1'b1;
`ifdef WTU_PAD_ON_LAST_EN
          if (in_last) begin
            sb.push_back({{W{1'b0}}, bus.in_data});
            have_half = 1'b0;
          end
`endif
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("rd_addr", bus.rd_addr, m_rp);
        m_rp = m_rp + 2'd1;
        pops++;
        if (sb.size() == 0) chk("pop_unexpected", 1, 0);
        else chk("pair", rd_data, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // reset, with in_valid high to confirm no write escapes
    bus.in_valid = 1'b1;
    bus.in_data = 24'h55;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf_err, 1'b0);
    bus.in_valid = 1'b0;
    cyc();
    rst = 1'b1;

    // four pushes, no consumer
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = W'(i);
      @(negedge clk);
      chk("fill_level", level, i - 1);
      chk("fill_out_valid", bus.out_valid, i >= 3);
      cyc();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("four_level", level, 4);
    chk("four_rd_addr", bus.rd_addr, 0);
    chk("four_pair", rd_data, {24'h000002, 24'h000001});
    cyc();
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("drain_level", level, 0);
    chk("drain_out_valid", bus.out_valid, 1'b0);

    // fill to full and keep pushing
    cyc();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = W'(32'h100 + i);
      cyc();
    end
    @(negedge clk);
    chk("full_in_ready", bus.in_ready, 1'b0);
    chk("full_level", level, 8);
    chk("full_ovf_pre", ovf_err, 1'b0);
    chk("full_wr_en", bus.wr_en, 1'b0);
    cyc();
    @(negedge clk);
    chk("ovf_set", ovf_err, 1'b1);

    // full with simultaneous offer and pop: only the pop happens
    cyc();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("fullpop_wr_en", bus.wr_en, 1'b0);
    cyc();
    bus.out_ready = 1'b0;
    bus.in_data = 24'h1FF;
    @(negedge clk);
    chk("fullpop_level", level, 6);
    chk("after_pop_in_ready", bus.in_ready, 1'b1);
    chk("after_pop_wr_en", bus.wr_en, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("refill_level", level, 7);
    chk("ovf_sticky", ovf_err, 1'b1);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("flush1_level", level, 0);
    chk("flush1_ovf", ovf_err, 1'b0);
    chk("flush1_out_valid", bus.out_valid, 1'b0);

    // streaming 20 samples with the consumer always ready
    cyc();
    p0 = pops;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = W'(i);
      cyc();
    end
    bus.in_valid = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    chk("stream_pops", pops - p0, 10);
    chk("stream_sb_empty", sb.size(), 0);
    chk("stream_ovf", ovf_err, 1'b0);
    chk("stream_level", level, 0);

    // flush with three stored and a concurrent push attempt
    cyc();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = W'(32'h30 + i);
      cyc();
    end
    flush = 1'b1;
    bus.in_data = 24'h77;
    @(negedge clk);
    chk("flush2_wr_en", bus.wr_en, 1'b0);
    cyc();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush2_level", level, 0);
    chk("flush2_out_valid", bus.out_valid, 1'b0);
    chk("flush2_ovf", ovf_err, 1'b0);
    chk("flush2_in_ready", bus.in_ready, 1'b1);
    cyc();

`ifdef WTU_PAD_ON_LAST_EN
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = W'(32'hA + i);
      in_last = (i == 2);
      cyc();
    end
    bus.in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    chk("pad_in_ready", bus.in_ready, 1'b0);
    chk("pad_wr_en", bus.wr_en, 1'b1);
    chk("pad_wr_addr", bus.wr_addr, 3);
    chk("pad_wr_data", bus.wr_data, 0);
    cyc();
    @(negedge clk);
    chk("pad_done_in_ready", bus.in_ready, 1'b1);
    chk("pad_level", level, 4);
    cyc();
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 24'hD;
    in_last = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    in_last = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("padrst_in_ready", bus.in_ready, 1'b1);
    chk("padrst_wr_en", bus.wr_en, 1'b0);
    chk("padrst_level", level, 0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("padrst_run_in_ready", bus.in_ready, 1'b1);
    cyc();
`endif

    chk("final_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
